multi_pulse_generator: RTL and testbench

- Multi-channel, run-time programmable successor to the single fixed-width edge-triggered pulse stretcher.
- Each channel detects a selectable edge on its trigger, waits a programmable delay, then drives a pulse of programmable width.
- A selectable retrigger policy decides what happens to edges that arrive while a channel is busy.
- Used for strobes, one-shots and bus-timing pulses; sits between the bus-decode logic and the peripherals that need timed enables.

---
 rtl/multi_pulse_generator.sv | 154 +++++++++++++++
 tb/tb_multi_pulse_generator.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_pulse_generator.sv
// Multi-channel programmable pulse generator: per-channel edge detect, programmable
// delay, then a pulse of programmable width, with a selectable retrigger policy.
module multi_pulse_generator #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned DELAY_W     = 8,
  parameter int unsigned WIDTH_W     = 8,
  parameter int unsigned SYNC_STAGES = 0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic [1:0]                  edge_sel,
  input  logic [1:0]                  retrig_mode,
  input  logic [CHANNELS-1:0]         trigger,
  input  logic [CHANNELS*DELAY_W-1:0] delay,
  input  logic [CHANNELS*WIDTH_W-1:0] width,
  output logic [CHANNELS-1:0]         pulse,
  output logic [CHANNELS-1:0]         busy,
  output logic [CHANNELS-1:0]         missed
);

  localparam int unsigned CNT_W = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;

  localparam logic [1:0] RM_RESTART = 2'b01;
  localparam logic [1:0] RM_EXTEND  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_ACTIVE = 2'd2
  } state_e;

  logic [CHANNELS-1:0] t_s;
  logic [CHANNELS-1:0] t_d_q;
  logic [CHANNELS-1:0] edge_c;

  // Optional trigger synchroniser chain
  if (SYNC_STAGES == 0) begin : g_nosync
    assign t_s = trigger;
  end else begin : g_sync
    logic [CHANNELS-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      end else begin
        sync_q[0] <= trigger;
        for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
    end

    assign t_s = sync_q[SYNC_STAGES-1];
  end

  // Edge history runs regardless of enable so re-enable only sees fresh edges
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) t_d_q <= '0;
    else          t_d_q <= t_s;
  end

  always_comb begin
    case (edge_sel)
      2'b01:   edge_c = ~t_s & t_d_q;
      2'b10:   edge_c = t_s ^ t_d_q;
      default: edge_c = t_s & ~t_d_q;
    endcase
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH_W-1:0] wlat_q, wlat_d;
    logic               pulse_q, busy_q, missed_q, missed_d;
    logic [DELAY_W-1:0] d_c;
    logic [WIDTH_W-1:0] w_c;

    assign d_c = delay[g*DELAY_W +: DELAY_W];
    assign w_c = width[g*WIDTH_W +: WIDTH_W];

    // Normal countdown first, then an edge may override it per retrigger policy
    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wlat_d   = wlat_q;
      missed_d = 1'b0;
      if (!enable) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          S_DELAY: begin
            if (cnt_q == '0) begin
              state_d = S_ACTIVE;
              cnt_d   = CNT_W'(wlat_q) - CNT_W'(1);
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
          S_ACTIVE: begin
            if (cnt_q == '0) state_d = S_IDLE;
            else             cnt_d   = cnt_q - CNT_W'(1);
          end
          S_IDLE:  ;
          default: state_d = S_IDLE;
        endcase

        if (edge_c[g]) begin
          if (state_q == S_IDLE || retrig_mode == RM_RESTART) begin
            if (w_c != '0) begin
              wlat_d = w_c;
              if (d_c == '0) begin
                state_d = S_ACTIVE;
                cnt_d   = CNT_W'(w_c) - CNT_W'(1);
              end else begin
                state_d = S_DELAY;
                cnt_d   = CNT_W'(d_c) - CNT_W'(1);
              end
            end else if (state_q != S_IDLE) begin
              missed_d = 1'b1;
            end
          end else if (retrig_mode == RM_EXTEND && state_q == S_ACTIVE && w_c != '0) begin
            state_d = S_ACTIVE;
            cnt_d   = CNT_W'(w_c) - CNT_W'(1);
          end else begin
            missed_d = 1'b1;
          end
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q  <= S_IDLE;
        cnt_q    <= '0;
        wlat_q   <= '0;
        pulse_q  <= 1'b0;
        busy_q   <= 1'b0;
        missed_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        wlat_q   <= wlat_d;
        pulse_q  <= (state_d == S_ACTIVE);
        busy_q   <= (state_d != S_IDLE);
        missed_q <= missed_d;
      end
    end

    assign pulse[g]  = pulse_q;
    assign busy[g]   = busy_q;
    assign missed[g] = missed_q;
  end

endmodule

// File: tb/tb_multi_pulse_generator.sv
// Bench for multi_pulse_generator: fixed vector table, hand sequences and random
// stimulus checked against an interval-based reference model (SYNC_STAGES 0 and 2).
module tb_multi_pulse_generator;

  localparam int unsigned CH   = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned WW   = 8;
  localparam int          HMAX = 4096;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             en = 1'b0;
  logic [1:0]       es = 2'b00;
  logic [1:0]       rm = 2'b00;
  logic [CH-1:0]    trig = '0;
  logic [CH*DW-1:0] dly = '0;
  logic [CH*WW-1:0] wid = '0;
  logic [CH-1:0]    pulse0, busy0, missed0;
  logic [CH-1:0]    pulse1, busy1, missed1;

  multi_pulse_generator #(.CHANNELS(CH), .DELAY_W(DW), .WIDTH_W(WW), .SYNC_STAGES(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .enable(en), .edge_sel(es), .retrig_mode(rm),
    .trigger(trig), .delay(dly), .width(wid),
    .pulse(pulse0), .busy(busy0), .missed(missed0)
  );

  multi_pulse_generator #(.CHANNELS(CH), .DELAY_W(DW), .WIDTH_W(WW), .SYNC_STAGES(2)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .enable(en), .edge_sel(es), .retrig_mode(rm),
    .trigger(trig), .delay(dly), .width(wid),
    .pulse(pulse1), .busy(busy1), .missed(missed1)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n = 0;
  int r = 1;

  // Model: each channel is an interval [acc, end) of busy cycles with pulse in [st, end)
  int            m_acc [2][CH];
  int            m_st  [2][CH];
  int            m_end [2][CH];
  logic [CH-1:0] m_miss[2];
  logic [CH-1:0] hist  [HMAX];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, n, act, exp);
    end
  endtask

  function automatic logic ts(input int u, input int c, input int k);
    int s;
    s = (u == 0) ? 0 : 2;
    if (k - s < r) return 1'b0;
    return hist[k-s][c];
  endfunction

  task automatic model_clear();
    for (int u = 0; u < 2; u++) begin
      m_miss[u] = '0;
      for (int c = 0; c < CH; c++) begin
        m_acc[u][c] = 0;
        m_st[u][c]  = 0;
        m_end[u][c] = 0;
      end
    end
  endtask

  task automatic model_step(input int k);
    logic a, b, e, busy_p, act_p;
    int   dv, wv;
    for (int u = 0; u < 2; u++) begin
      for (int c = 0; c < CH; c++) begin
        m_miss[u][c] = 1'b0;
        a  = ts(u, c, k);
        b  = ts(u, c, k - 1);
        e  = (es == 2'b01) ? (!a && b) : (es == 2'b10) ? (a != b) : (a && !b);
        dv = int'(dly[c*DW +: DW]);
        wv = int'(wid[c*WW +: WW]);
        busy_p = (m_acc[u][c] <= k - 1) && (k - 1 < m_end[u][c]);
        act_p  = (m_st[u][c]  <= k - 1) && (k - 1 < m_end[u][c]);
        if (!en) begin
          m_acc[u][c] = k;
          m_st[u][c]  = k;
          m_end[u][c] = k;
        end else if (e) begin
          if (!busy_p || rm == 2'b01) begin
            if (wv > 0) begin
              m_acc[u][c] = k;
              m_st[u][c]  = k + dv;
              m_end[u][c] = k + dv + wv;
            end else if (busy_p) begin
              m_miss[u][c] = 1'b1;
            end
          end else if (rm == 2'b10 && act_p && wv > 0) begin
            m_end[u][c] = k + wv;
          end else begin
            m_miss[u][c] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic check_model();
    logic [CH-1:0] ep, eb;
    for (int u = 0; u < 2; u++) begin
      for (int c = 0; c < CH; c++) begin
        ep[c] = (m_st[u][c]  <= n) && (n < m_end[u][c]);
        eb[c] = (m_acc[u][c] <= n) && (n < m_end[u][c]);
      end
      chk($sformatf("model_pulse_s%0d", 2*u),  32'(u == 0 ? pulse0  : pulse1),  32'(ep));
      chk($sformatf("model_busy_s%0d", 2*u),   32'(u == 0 ? busy0   : busy1),   32'(eb));
      chk($sformatf("model_missed_s%0d", 2*u), 32'(u == 0 ? missed0 : missed1), 32'(m_miss[u]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    n++;
    hist[n] = trig;
    if (reset_n) model_step(n);
    #1;
    check_model();
  endtask

  typedef struct packed {
    logic          en;
    logic [1:0]    es;
    logic [1:0]    rm;
    logic [CH-1:0] trig;
    logic [CH-1:0] p;
    logic [CH-1:0] b;
    logic [CH-1:0] m;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int cnt, input logic e, input logic [1:0] s, input logic [1:0] m,
                     input logic [3:0] t, input logic [3:0] p, input logic [3:0] b,
                     input logic [3:0] ms);
    for (int i = 0; i < cnt; i++) tbl.push_back({e, s, m, t, p, b, ms});
  endtask

  initial begin
    model_clear();
    // ch0 D0 W3, ch1 D4 W2, ch2 D0 W5, ch3 D1 W1
    dly = {8'd1, 8'd0, 8'd4, 8'd0};
    wid = {8'd1, 8'd5, 8'd2, 8'd3};
    en  = 1'b1;
    tick();
    tick();
    #3 reset_n = 1'b1;
    r = n + 1;

    // Rising/IGNORE, then RESTART, then EXTEND on ch2; then both-edges on ch3
    add(1, 1, 2'b00, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1, 1, 2'b00, 2'b00, 4'b0101, 4'b0101, 4'b0101, 4'b0000);
    add(1, 1, 2'b00, 2'b00, 4'b0001, 4'b0101, 4'b0101, 4'b0000);
    add(1, 1, 2'b00, 2'b00, 4'b0101, 4'b0101, 4'b0101, 4'b0100);
    add(2, 1, 2'b00, 2'b00, 4'b0001, 4'b0100, 4'b0100, 4'b0000);
    add(1, 1, 2'b00, 2'b00, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
    add(1, 1, 2'b00, 2'b01, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1, 1, 2'b00, 2'b01, 4'b0100, 4'b0100, 4'b0100, 4'b0000);
    add(1, 1, 2'b00, 2'b01, 4'b0000, 4'b0100, 4'b0100, 4'b0000);
    add(1, 1, 2'b00, 2'b01, 4'b0100, 4'b0100, 4'b0100, 4'b0000);
    add(4, 1, 2'b00, 2'b01, 4'b0000, 4'b0100, 4'b0100, 4'b0000);
    add(1, 1, 2'b00, 2'b01, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1, 1, 2'b00, 2'b10, 4'b0100, 4'b0100, 4'b0100, 4'b0000);
    add(1, 1, 2'b00, 2'b10, 4'b0000, 4'b0100, 4'b0100, 4'b0000);
    add(1, 1, 2'b00, 2'b10, 4'b0100, 4'b0100, 4'b0100, 4'b0000);
    add(4, 1, 2'b00, 2'b10, 4'b0000, 4'b0100, 4'b0100, 4'b0000);
    add(1, 1, 2'b00, 2'b10, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add(1, 1, 2'b10, 2'b00, 4'b1000, 4'b0000, 4'b1000, 4'b0000);
    add(1, 1, 2'b10, 2'b00, 4'b1000, 4'b1000, 4'b1000, 4'b0000);
    add(2, 1, 2'b10, 2'b00, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
    add(1, 1, 2'b10, 2'b00, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    add(1, 1, 2'b10, 2'b00, 4'b0000, 4'b1000, 4'b1000, 4'b0000);
    add(1, 1, 2'b10, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    for (int i = 0; i < tbl.size(); i++) begin
      en = tbl[i].en; es = tbl[i].es; rm = tbl[i].rm; trig = tbl[i].trig;
      tick();
      chk($sformatf("tbl%0d_pulse", i),  32'(pulse0),  32'(tbl[i].p));
      chk($sformatf("tbl%0d_busy", i),   32'(busy0),   32'(tbl[i].b));
      chk($sformatf("tbl%0d_missed", i), 32'(missed0), 32'(tbl[i].m));
    end
    es = 2'b00; rm = 2'b00; trig = '0;
    repeat (4) tick();

    // Two-stage synchroniser: ch1 D4 W2 pulses 6..7 cycles after the edge
    trig = 4'b0010;
    for (int j = 0; j < 10; j++) begin
      if (j == 2) trig = '0;
      tick();
      chk("sync2_pulse", 32'(pulse1[1]), 32'(j == 6 || j == 7));
      chk("sync2_busy",  32'(busy1[1]),  32'(j >= 2 && j <= 7));
    end

    // Mid-pulse disable, then re-enable with trigger still high
    wid[0*WW +: WW] = 8'd10;
    trig = 4'b0001;
    for (int j = 0; j < 8; j++) begin
      en = (j != 3);
      tick();
      chk("dis_pulse",  32'(pulse0[0]),  32'(j < 3));
      chk("dis_busy",   32'(busy0[0]),   32'(j < 3));
      chk("dis_missed", 32'(missed0[0]), 32'(0));
    end
    trig = '0;
    repeat (3) tick();

    // Zero width: edge is ignored outright, no missed strobe
    wid[3*WW +: WW] = 8'd0;
    rm = 2'b01;
    trig = 4'b1000;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("w0_activity", 32'({pulse0[3], busy0[3], missed0[3]}), 32'(0));
    end
    trig = '0; rm = 2'b00;
    repeat (3) tick();

    // Async reset while every channel is in DELAY; trigger held high across release
    dly = {4{8'd5}};
    wid = {4{8'd2}};
    trig = 4'b1111;
    repeat (4) tick();
    chk("pre_rst_busy0", 32'(busy0), 32'hF);
    chk("pre_rst_busy1", 32'(busy1), 32'hF);
    #3 reset_n = 1'b0;
    model_clear();
    #1;
    chk("async_rst_s0", 32'({pulse0, busy0, missed0}), 32'(0));
    chk("async_rst_s2", 32'({pulse1, busy1, missed1}), 32'(0));
    tick();
    tick();
    #3 reset_n = 1'b1;
    r = n + 1;
    tick();
    chk("post_rst_busy0",  32'(busy0),  32'hF);
    chk("post_rst_pulse0", 32'(pulse0), 32'h0);
    repeat (8) tick();

    // Random phase against the model
    for (int j = 0; j < 2000; j++) begin
      if (j % 16 == 0) begin
        es = 2'($urandom_range(0, 3));
        rm = 2'($urandom_range(0, 3));
        for (int c = 0; c < CH; c++) begin
          dly[c*DW +: DW] = 8'($urandom_range(0, 6));
          wid[c*WW +: WW] = 8'($urandom_range(0, 6));
        end
      end
      en = ($urandom_range(0, 19) != 0);
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 3) == 0) trig[c] = ~trig[c];
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
